mem_initiator: RTL
==================

Name: mem_initiator

Overview:
- Bus-side initiator for MEMCTRL. It converts a valid/ready request stream (single read or write per request) into MEMCTRL strobe sequences on ADDR/CE/CSB/WEB/OEB/IDATA.
- For reads, it captures ODATA and returns it on a one-cycle response pulse.
- It sits between the on-chip control logic and MEMCTRL, so system blocks can reach the memory without hand-timed strobes.

Parameters:
- AW, 16, address width (matches MEMCTRL ADDR).
- DW, 8, data width (matches MEMCTRL IDATA/ODATA).
- RD_LAT, 1, cycles from the access-cycle sampling edge to the edge at which ODATA is valid; range 1..4.
- RECOVER_CYC, 1, idle cycles (CE=0, CSB=1) forced after every access; range 1..7.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when both req_valid and req_ready are 1.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  access address.
- req_wdata  in  DW  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse; read data valid.
- rsp_rdata  out  DW  read data; held until the next rsp_valid.
- ADDR  out  AW  to MEMCTRL.
- CE  out  1  to MEMCTRL, active high.
- CSB  out  1  to MEMCTRL, active low.
- WEB  out  1  to MEMCTRL, active low.
- OEB  out  1  to MEMCTRL, active low.
- IDATA  out  DW  to MEMCTRL.
- ODATA  in  DW  from MEMCTRL.
- err  out  1  sticky write-verify mismatch flag (only when MEMINIT_WRVERIFY_EN is defined; otherwise tied 0).

Behaviour:
- One clock (CLK). Reset is asynchronous, active-low (RSTN).
- All MEMCTRL-side outputs are registered.
- Reset values: ADDR=0, CE=0, CSB=1, WEB=1, OEB=1, IDATA=0, req_ready=0, rsp_valid=0, rsp_rdata=0, err=0.
- req_ready rises in the first cycle after RSTN deasserts.
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE:
  - req_ready=1; strobes are inactive.
  - On accept, the edge registers addr/we/wdata and moves to ACCESS.
- ACCESS (exactly 1 cycle):
  - ADDR=addr, CE=1, CSB=0.
  - Write: WEB=0, OEB=1, IDATA=wdata.
  - Read: WEB=1, OEB=0, IDATA=0.
  - req_ready=0.
  - Next state is RECOVER, with the recover counter loaded to RECOVER_CYC.
- RECOVER:
  - CE=0, CSB=1, WEB=1, OEB=1, IDATA=0; ADDR holds its last value.
  - Counter decrements each cycle.
  - Exit to IDLE when counter reaches 0 AND no read capture is pending.
- Read capture:
  - Define the access cycle as cycle k.
  - ODATA is sampled at the rising edge ending cycle k+RD_LAT, using a shift-register tag.
  - rsp_rdata is loaded and rsp_valid=1 during cycle k+RD_LAT+1 only.
- Throughput (RECOVER_CYC=1, RD_LAT=1):
  - Write: 3 cycles per transaction (accept, ACCESS, RECOVER).
  - Read: same 3 cycles; rsp_valid appears in the cycle after RECOVER, coincident with IDLE, so back-to-back reads sustain 1 access per 3 cycles.
- Requests are never dropped and never reordered; req_ready=0 in any non-IDLE state.
- req_* inputs are sampled only on accept; changes at other times are ignored.
- Reset mid-operation: strobes return to reset values immediately (asynchronous). Any pending read is discarded with no rsp_valid. err clears.
- ADDR is passed straight through, no wrap logic; the full AW range, including all-ones, is legal.

Optional Feature:
- Macro: MEMINIT_WRVERIFY_EN.
- When defined:
  - Every accepted write is followed, after its RECOVER, by an automatic read of the same address (extra states VERIFY_ACCESS and VERIFY_RECOVER, same timing as a read).
  - req_ready stays 0 until the verify read completes.
  - The captured data is compared with the written data; a mismatch sets err (sticky until reset).
  - The verify read never produces rsp_valid.
  - Write cost becomes 5 cycles at default parameters.
- When undefined: no verify states; err is tied 0.

Test Plan:
- Reset release:
  - During RSTN=0, outputs equal the reset values (CSB=1, CE=0, WEB=OEB=1).
  - One cycle after release, req_ready=1.
- Single write (addr 0x0005, wdata 0xA5):
  - Exactly one cycle with CE=1, CSB=0, WEB=0, OEB=1, ADDR=0x0005, IDATA=0xA5.
  - Then 1 recover cycle, then req_ready=1.
- Read-back of 0x0005:
  - One cycle with OEB=0, WEB=1.
  - rsp_valid pulses once with rsp_rdata=0xA5, 2 cycles after the access cycle.
- Ten alternating write/read pairs (random data, addresses 0x0000..0x0009), with req_valid held high:
  - Every read returns the data of the preceding write.
  - There is no cycle with CE=1 adjacent to another cycle with CE=1.
- RSTN asserted during the RECOVER of a read:
  - No rsp_valid follows; strobes are inactive immediately.
  - After release, a new read completes normally.
- With MEMINIT_WRVERIFY_EN defined and ODATA forced to 0x00:
  - A write of 0x3C sets err=1; no rsp_valid is generated.
  - err stays 1 until RSTN=0.

Source files
------------

// File: rtl/mem_initiator.sv
// mem_initiator: valid/ready request stream to MEMCTRL strobe sequencer with read-data capture.
// Optional write-verify read-back with sticky err flag is enabled by defining MEMINIT_WRVERIFY_EN.
module mem_initiator #(
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int RD_LAT      = 1,
  parameter int RECOVER_CYC = 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] ADDR,
  output logic          CE,
  output logic          CSB,
  output logic          WEB,
  output logic          OEB,
  output logic [DW-1:0] IDATA,
  input  logic [DW-1:0] ODATA,
  output logic          err
);
`ifdef MEMINIT_WRVERIFY_EN
  typedef enum logic [2:0] {IDLE, ACCESS, RECOVER, VERIFY_ACCESS, VERIFY_RECOVER} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
`endif
  state_t          r_state;
  logic            r_ready;
  logic [AW-1:0]   r_addr;
  logic            r_ce;
  logic            r_csb;
  logic            r_web;
  logic            r_oeb;
  logic [DW-1:0]   r_idata;
  logic [2:0]      r_cnt;
  logic [RD_LAT-1:0] r_tag;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_rdata;
  logic            w_launch;
  logic            w_cap;
  logic            w_pend;
  logic            w_done;
  logic            w_vfy;
`ifdef MEMINIT_WRVERIFY_EN
  logic            r_we;
  logic [DW-1:0]   r_wdata;
  logic            r_vfy;
  logic            r_err;
  assign w_vfy = r_vfy;
  assign err   = r_err;
`else
  assign w_vfy = 1'b0;
  assign err   = 1'b0;
`endif
  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign ADDR      = r_addr;
  assign CE        = r_ce;
  assign CSB       = r_csb;
  assign WEB       = r_web;
  assign OEB       = r_oeb;
  assign IDATA     = r_idata;
  assign w_launch  = r_ce & ~r_oeb;
  assign w_cap     = r_tag[RD_LAT-1];
  assign w_done    = (r_cnt <= 3'd1) && !w_pend;
  // a read is still in flight if its tag has not yet reached the capture stage
  always_comb begin
    w_pend = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) w_pend = w_pend | r_tag[i];
  end
  // access sequencer: every strobe and req_ready is registered here
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_addr  <= '0;
      r_ce    <= 1'b0;
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_oeb   <= 1'b1;
      r_idata <= '0;
      r_cnt   <= '0;
`ifdef MEMINIT_WRVERIFY_EN
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_vfy   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && r_ready) begin
            r_state <= ACCESS;
            r_ready <= 1'b0;
            r_addr  <= req_addr;
            r_ce    <= 1'b1;
            r_csb   <= 1'b0;
            r_web   <= ~req_we;
            r_oeb   <= req_we;
            r_idata <= req_we ? req_wdata : '0;
`ifdef MEMINIT_WRVERIFY_EN
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_vfy   <= 1'b0;
`endif
          end else begin
            r_ready <= 1'b1;
          end
        end
        ACCESS: begin
          r_state <= RECOVER;
          r_ce    <= 1'b0;
          r_csb   <= 1'b1;
          r_web   <= 1'b1;
          r_oeb   <= 1'b1;
          r_idata <= '0;
          r_cnt   <= 3'(RECOVER_CYC);
        end
        RECOVER: begin
          if (w_done) begin
`ifdef MEMINIT_WRVERIFY_EN
            if (r_we) begin
              r_state <= VERIFY_ACCESS;
              r_ce    <= 1'b1;
              r_csb   <= 1'b0;
              r_oeb   <= 1'b0;
              r_vfy   <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_ready <= 1'b1;
            end
`else
            r_state <= IDLE;
            r_ready <= 1'b1;
`endif
          end else if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
`ifdef MEMINIT_WRVERIFY_EN
        VERIFY_ACCESS: begin
          r_state <= VERIFY_RECOVER;
          r_ce    <= 1'b0;
          r_csb   <= 1'b1;
          r_oeb   <= 1'b1;
          r_cnt   <= 3'(RECOVER_CYC);
        end
        VERIFY_RECOVER: begin
          if (w_done) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end else if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
  // read-latency tag pipeline and response capture; verify reads never respond
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_tag       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_tag[0] <= w_launch;
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
      r_rsp_valid <= w_cap & ~w_vfy;
      if (w_cap && !w_vfy) r_rsp_rdata <= ODATA;
    end
  end
`ifdef MEMINIT_WRVERIFY_EN
  // sticky mismatch between verify read-back and the data just written
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_err <= 1'b0;
    else if (w_cap && r_vfy && ODATA != r_wdata) r_err <= 1'b1;
  end
`endif
endmodule
